// File: rtl/reset_ctrl_pkg.sv
// Shared definitions for the reset controller: register map, REASON/CTRL bit
// positions, the reset FSM state type and the captured bus request.
package reset_ctrl_pkg;

   localparam logic [1:0] CTRL_W   = 2'd0;
   localparam logic [1:0] REASON_W = 2'd1;
   localparam logic [1:0] STATUS_W = 2'd2;

   localparam int RSN_POR    = 0;
   localparam int RSN_EXT    = 1;
   localparam int RSN_NDM    = 2;
   localparam int RSN_SW_SYS = 3;
   localparam int RSN_SW_ALL = 4;
   localparam int RSN_BITS   = 5;

   localparam int CTRL_SYS = 0;
   localparam int CTRL_ALL = 1;

   typedef enum logic [1:0] {ST_ALL, ST_SYS, ST_RUN} reset_state_e;

   typedef struct packed {
      logic                vld;
      logic                we;
      logic                sel0;
      logic [1:0]          adr;
      logic [RSN_BITS-1:0] dat;
   } wb_req_t;

endpackage

// File: rtl/reset_ctrl_sync_ff.sv
// Multi-stage synchronizer for an asynchronous level; all stages clear on rst.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ff <= '0;
      else     ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_ctrl.sv
// Central reset controller: stretches POR / button / ndmreset / software
// requests into clk-synchronous sys and debug resets, with a small WB slave.
module reset_ctrl
   import reset_ctrl_pkg::*;
#(
   parameter int RST_PULSE_CYCLES = 32,
   parameter int SYNC_STAGES      = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ext_rst_n_i,
   input  logic        ndmreset_i,
   input  logic [1:0]  wb_adr,
   input  logic [31:0] wb_dat_m,
   input  logic [3:0]  wb_sel,
   input  logic        wb_we,
   input  logic        wb_cyc,
   input  logic        wb_stb,
   output logic [31:0] wb_dat_s,
   output logic        wb_ack,
   output logic        wb_stall,
   output logic        wb_err,
   output logic        sys_rst_n_o,
   output logic        dm_rst_n_o
);

   localparam int            CW       = $clog2(RST_PULSE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(RST_PULSE_CYCLES);

   reset_state_e        state, state_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic                ext_sync, ext_sync_q, ndm_q;
   logic                sw_sys_q, sw_all_q;
   logic                req_all, req_sys, ctrl_wr;
   logic [RSN_BITS-1:0] reason, rsn_set, rsn_clr;
   logic [31:0]         rdata;
   wb_req_t             req;
   logic                unused_bits;

   assign unused_bits = ^{wb_sel[3:1], wb_dat_m[31:RSN_BITS]};
   assign wb_stall    = 1'b0;
   assign wb_err      = 1'b0;

   sync_ff #(.STAGES(SYNC_STAGES)) u_ext_sync (
      .clk (clk),
      .rst (rst),
      .d   (~ext_rst_n_i),
      .q   (ext_sync)
   );

   assign req = '{vld:  wb_cyc & wb_stb,
                  we:   wb_we,
                  sel0: wb_sel[0],
                  adr:  wb_adr,
                  dat:  wb_dat_m[RSN_BITS-1:0]};

   assign ctrl_wr = req.vld & req.we & req.sel0 & (req.adr == CTRL_W);
   assign req_all = ext_sync | sw_all_q;
   assign req_sys = ndmreset_i | sw_sys_q;

   // Priority: any all-class request beats sys-class; sys-class inside
   // ST_ALL only extends the stretch.
   always_comb begin
      state_n = state;
      cnt_n   = (cnt == '0) ? '0 : cnt - 1'b1;
      unique case (state)
         ST_ALL: begin
            if (req_all || req_sys) cnt_n   = CNT_LOAD;
            else if (cnt == '0)     state_n = ST_RUN;
         end
         ST_SYS: begin
            if (req_all) begin
               state_n = ST_ALL;
               cnt_n   = CNT_LOAD;
            end else if (req_sys) begin
               cnt_n   = CNT_LOAD;
            end else if (cnt == '0) begin
               state_n = ST_RUN;
            end
         end
         ST_RUN: begin
            if (req_all) begin
               state_n = ST_ALL;
               cnt_n   = CNT_LOAD;
            end else if (req_sys) begin
               state_n = ST_SYS;
               cnt_n   = CNT_LOAD;
            end
         end
         default: begin
            state_n = ST_ALL;
            cnt_n   = CNT_LOAD;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_ALL;
         cnt         <= CNT_LOAD;
         sys_rst_n_o <= 1'b0;
         dm_rst_n_o  <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         sys_rst_n_o <= (state_n == ST_RUN);
         dm_rst_n_o  <= (state_n != ST_ALL);
      end
   end

   always_comb begin
      rsn_set             = '0;
      rsn_set[RSN_EXT]    = ext_sync & ~ext_sync_q;
      rsn_set[RSN_NDM]    = ndmreset_i & ~ndm_q;
      rsn_set[RSN_SW_SYS] = sw_sys_q;
      rsn_set[RSN_SW_ALL] = sw_all_q;
      rsn_clr             = '0;
      if (req.vld && req.we && req.sel0 && req.adr == REASON_W) rsn_clr = req.dat;
   end

   always_comb begin
      rdata = '0;
      unique case (req.adr)
         REASON_W: rdata = {{(32-RSN_BITS){1'b0}}, reason};
         STATUS_W: rdata = {30'b0, dm_rst_n_o, sys_rst_n_o};
         default:  rdata = '0;
      endcase
   end

   // Software requests fire one cycle after the write so the ack leaves first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ext_sync_q <= 1'b0;
         ndm_q      <= 1'b0;
         sw_sys_q   <= 1'b0;
         sw_all_q   <= 1'b0;
         reason     <= RSN_BITS'(1) << RSN_POR;
         wb_ack     <= 1'b0;
         wb_dat_s   <= '0;
      end else begin
         ext_sync_q <= ext_sync;
         ndm_q      <= ndmreset_i;
         sw_all_q   <= ctrl_wr & req.dat[CTRL_ALL];
         sw_sys_q   <= ctrl_wr & req.dat[CTRL_SYS] & ~req.dat[CTRL_ALL];
         reason     <= (reason & ~rsn_clr) | rsn_set;
         wb_ack     <= req.vld;
         wb_dat_s   <= (req.vld && !req.we) ? rdata : '0;
      end
   end

endmodule

// File: tb/tb_reset_ctrl.sv
// Bench for reset_ctrl: directed scenarios then random traffic, every cycle
// compared against an episode-based behavioural model.
module tb_reset_ctrl;

   localparam int P = 32;
   localparam int S = 2;

   logic        clk = 1'b0, rst = 1'b0, ext_n = 1'b1, ndm = 1'b0;
   logic [1:0]  adr = '0;
   logic [31:0] dat_m = '0;
   logic [3:0]  sel = '0;
   logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
   logic [31:0] wb_dat_s;
   logic        wb_ack, wb_stall, wb_err, sys_rst_n_o, dm_rst_n_o;

   reset_ctrl #(.RST_PULSE_CYCLES(P), .SYNC_STAGES(S)) dut (
      .clk(clk), .rst(rst), .ext_rst_n_i(ext_n), .ndmreset_i(ndm),
      .wb_adr(adr), .wb_dat_m(dat_m), .wb_sel(sel), .wb_we(we),
      .wb_cyc(cyc), .wb_stb(stb), .wb_dat_s(wb_dat_s), .wb_ack(wb_ack),
      .wb_stall(wb_stall), .wb_err(wb_err),
      .sys_rst_n_o(sys_rst_n_o), .dm_rst_n_o(dm_rst_n_o)
   );

   always #10 clk = ~clk;

   int n_tests = 0, n_fail = 0;

   // Model: a reset "episode" lasts until P edges after its last request;
   // the debug domain is held only if an all-class request joined the episode.
   int          k = 0, last_req = 0;
   bit          ep_all = 1'b1;
   bit          q[$];
   bit          ext_p, ndm_p, sch_all, sch_sys;
   logic [4:0]  reason = 5'h1;
   logic        e_sys_n = 1'b0, e_dm_n = 1'b0, e_ack = 1'b0;
   logic [31:0] e_dat = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit ext_s, all_req, sys_req, n_all, n_sys;
      logic [4:0] set, clr;
      k++;
      if (rst) begin
         last_req = k; ep_all = 1'b1;
         q = {};
         for (int i = 0; i < S; i++) q.push_back(1'b0);
         ext_p = 0; ndm_p = 0; sch_all = 0; sch_sys = 0;
         reason = 5'h1; e_ack = 0; e_dat = '0; e_sys_n = 0; e_dm_n = 0;
         return;
      end
      ext_s = q.pop_front();
      q.push_back(!ext_n);
      all_req = ext_s | sch_all;
      sys_req = ndm | sch_sys;
      set = {sch_all, sch_sys, ndm & !ndm_p, ext_s & !ext_p, 1'b0};
      ext_p = ext_s; ndm_p = ndm;
      n_all = 0; n_sys = 0; clr = '0;
      e_ack = cyc & stb;
      e_dat = '0;
      if (cyc && stb) begin
         if (!we) begin
            if (adr == 2'd1) e_dat = {27'b0, reason};
            else if (adr == 2'd2) e_dat = {30'b0, e_dm_n, e_sys_n};
         end else if (sel[0]) begin
            if (adr == 2'd0) begin
               if (dat_m[1]) n_all = 1;
               else if (dat_m[0]) n_sys = 1;
            end else if (adr == 2'd1) clr = dat_m[4:0];
         end
      end
      reason = (reason & ~clr) | set;
      sch_all = n_all; sch_sys = n_sys;
      if (all_req || sys_req) begin
         if (k - last_req > P + 1) ep_all = 1'b0;
         ep_all |= all_req;
         last_req = k;
      end
      e_sys_n = !(k - last_req <= P);
      e_dm_n  = !((k - last_req <= P) && ep_all);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      chk("sys_rst_n", 32'(sys_rst_n_o), 32'(e_sys_n));
      chk("dm_rst_n", 32'(dm_rst_n_o), 32'(e_dm_n));
      chk("wb_ack", 32'(wb_ack), 32'(e_ack));
      chk("wb_dat_s", wb_dat_s, e_dat);
   endtask

   task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
      cyc = 1; stb = 1; we = 1; adr = a; dat_m = d; sel = 4'h1;
      step();
      cyc = 0; stb = 0; we = 0;
   endtask

   task automatic wb_rd(input logic [1:0] a, output logic [31:0] d);
      cyc = 1; stb = 1; we = 0; adr = a; sel = 4'h1;
      step();
      d = wb_dat_s;
      cyc = 0; stb = 0;
   endtask

   task automatic count_low(output int n);
      n = 0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (sys_rst_n_o === 1'b0) n++;
         else break;
      end
   endtask

   task automatic wait_run();
      int i;
      i = 0;
      while (!(sys_rst_n_o === 1'b1 && dm_rst_n_o === 1'b1) && i < 300) begin
         step();
         i++;
      end
      chk("run_reached", {30'b0, dm_rst_n_o, sys_rst_n_o}, 32'h3);
   endtask

   initial begin
      logic [31:0] rd;
      int n, n0;
      #1 rst = 1;
      // POR
      repeat (5) step();
      chk("por_sys_low", 32'(sys_rst_n_o), 32'h0);
      rst = 0;
      count_low(n);
      chk("por_len", n, P);
      wb_rd(2'd1, rd);
      chk("reason_por", rd, 32'h01);
      // ndmreset single pulse
      ndm = 1;
      step();
      n0 = (sys_rst_n_o === 1'b0) ? 1 : 0;
      chk("ndm_dm_held_high", 32'(dm_rst_n_o), 32'h1);
      ndm = 0;
      count_low(n);
      chk("ndm_len", n + n0, P + 1);
      wb_rd(2'd1, rd);
      chk("reason_ndm", rd, 32'h05);
      // Button held 100 cycles
      ext_n = 0;
      repeat (100) step();
      chk("btn_dm_low", 32'(dm_rst_n_o), 32'h0);
      ext_n = 1;
      count_low(n);
      chk("btn_tail_len", n, P + S);
      wb_rd(2'd1, rd);
      chk("reason_btn", rd, 32'h07);
      wb_wr(2'd1, 32'h1F);
      wb_rd(2'd1, rd);
      chk("reason_w1c", rd, 32'h00);
      // Software sys reset: ack at N+1, reset at N+2
      wb_wr(2'd0, 32'h1);
      chk("sw_ack", 32'(wb_ack), 32'h1);
      chk("sw_sys_not_yet", 32'(sys_rst_n_o), 32'h1);
      step();
      chk("sw_sys_low", 32'(sys_rst_n_o), 32'h0);
      wb_rd(2'd2, rd);
      chk("status_in_sys", rd, 32'h2);
      wait_run();
      wb_rd(2'd1, rd);
      chk("reason_sw_sys", rd, 32'h08);
      // ndmreset then button mid-pulse escalates to ST_ALL
      wb_wr(2'd1, 32'h1F);
      ndm = 1;
      repeat (5) step();
      chk("prio_dm_before", 32'(dm_rst_n_o), 32'h1);
      ext_n = 0;
      repeat (5) step();
      chk("prio_dm_dropped", 32'(dm_rst_n_o), 32'h0);
      ndm = 0; ext_n = 1;
      wait_run();
      wb_wr(2'd1, 32'h1F);
      wb_wr(2'd0, 32'h3);
      step();
      chk("sw_all_dm_low", 32'(dm_rst_n_o), 32'h0);
      wait_run();
      wb_rd(2'd1, rd);
      chk("reason_sw_all", rd, 32'h10);
      // Asynchronous rst in the middle of a sys stretch
      ndm = 1; step(); ndm = 0;
      repeat (4) step();
      @(negedge clk);
      rst = 1;
      #1;
      chk("async_sys", 32'(sys_rst_n_o), 32'h0);
      chk("async_dm", 32'(dm_rst_n_o), 32'h0);
      step(); step();
      rst = 0;
      wait_run();
      wb_rd(2'd1, rd);
      chk("reason_after_rst", rd, 32'h01);
      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         int r;
         r = $urandom_range(0, 999);
         if (r < 2) begin
            rst = 1; step(); step(); rst = 0;
         end else begin
            if (ext_n && $urandom_range(0, 199) == 0) ext_n = 0;
            else if (!ext_n && $urandom_range(0, 9) == 0) ext_n = 1;
            ndm = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 9) == 0) begin
               cyc = 1; stb = 1;
               we    = 1'($urandom_range(0, 1));
               adr   = 2'($urandom_range(0, 3));
               sel   = 4'($urandom_range(0, 15));
               dat_m = $urandom;
               if (we && adr == 2'd0 && $urandom_range(0, 3) != 0) dat_m[1:0] = 2'b00;
            end
            step();
            cyc = 0; stb = 0; we = 0;
         end
      end
      ndm = 0; ext_n = 1;
      wait_run();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
